// File: rtl/aes_encryption_multicycle_if.sv
// Block/result handshake bundle for the iterative AES-256 encryptor.
// The master side produces key/plaintext and consumes ciphertext.
interface aes_encryption_multicycle_if;
  logic [255:0] key_i;
  logic [127:0] plaintext_i;
  logic         v_i;
  logic         ready_o;
  logic [127:0] ciphertext_o;
  logic         v_o;
  logic         yumi_i;

  modport master (output key_i, plaintext_i, v_i, yumi_i,
                  input  ready_o, ciphertext_o, v_o);
  modport slave  (input  key_i, plaintext_i, v_i, yumi_i,
                  output ready_o, ciphertext_o, v_o);
endinterface

// File: rtl/aes_encryption_multicycle.sv
// Iterative AES-256 encryptor: one round per clock.
// Round keys are expanded on the fly, one round ahead of use.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine map
  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
  assign x2   = gmul(a, a);
  assign x3   = gmul(x2, a);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign inv  = gmul(x252, x2);
  assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// One state column: SubBytes on an already row-shifted column, plus MixColumns.
module aes_enc_col (
  input  logic [3:0][7:0] a,
  output logic [3:0][7:0] sb,
  output logic [3:0][7:0] mc
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar r = 0; r < 4; r++) begin : g_sb
    aes_sbox u_sbox (.a(a[r]), .s(sb[r]));
  end

  assign mc[0] = xt(sb[0]) ^ xt(sb[1]) ^ sb[1] ^ sb[2] ^ sb[3];
  assign mc[1] = sb[0] ^ xt(sb[1]) ^ xt(sb[2]) ^ sb[2] ^ sb[3];
  assign mc[2] = sb[0] ^ sb[1] ^ xt(sb[2]) ^ xt(sb[3]) ^ sb[3];
  assign mc[3] = xt(sb[0]) ^ sb[0] ^ sb[1] ^ sb[2] ^ xt(sb[3]);
endmodule

module aes_encryption_multicycle (
  input logic clk_i,
  input logic reset_n_i,
  aes_encryption_multicycle_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t fsm, fsm_nxt;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic [127:0] blk, ct;
  logic [255:0] k;   // {RK[r-1], RK[r]} while round r is pending

  logic [3:0][3:0][7:0] col_in, col_sb, col_mc;
  logic [127:0] rnd_sub, rnd_mix;

  // ShiftRows is a pure byte permutation, folded into the column gather
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign col_in[c][r] = blk[127-8*(r+4*((c+r)%4)) -: 8];
      assign rnd_sub[127-8*(r+4*c) -: 8] = col_sb[c][r];
      assign rnd_mix[127-8*(r+4*c) -: 8] = col_mc[c][r];
    end
    aes_enc_col u_col (.a(col_in[c]), .sb(col_sb[c]), .mc(col_mc[c]));
  end

  // Next four key words; odd rounds use RotWord+rcon, even rounds plain SubWord
  logic [31:0] sw_in, sw_out, t_word, n0, n1, n2, n3;
  assign sw_in = rnd[0] ? {k[23:0], k[31:24]} : k[31:0];
  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_sbox (.a(sw_in[8*j +: 8]), .s(sw_out[8*j +: 8]));
  end
  assign t_word = sw_out ^ (rnd[0] ? {rcon, 24'h0} : 32'h0);
  assign n0 = k[255:224] ^ t_word;
  assign n1 = k[223:192] ^ n0;
  assign n2 = k[191:160] ^ n1;
  assign n3 = k[159:128] ^ n2;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) fsm <= IDLE;
    else            fsm <= fsm_nxt;

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (bus.v_i)        fsm_nxt = BUSY;
      BUSY:    if (rnd == 4'd14)   fsm_nxt = DONE;
      DONE:    if (bus.yumi_i)     fsm_nxt = IDLE;
      default:                     fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rnd  <= 4'd0;
      rcon <= 8'h01;
      blk  <= '0;
      k    <= '0;
      ct   <= '0;
    end else begin
      case (fsm)
        IDLE: if (bus.v_i) begin
          blk  <= bus.plaintext_i ^ bus.key_i[255:128];
          k    <= bus.key_i;
          rnd  <= 4'd1;
          rcon <= 8'h01;
        end
        BUSY: begin
          if (rnd == 4'd14) begin
            ct <= rnd_sub ^ k[127:0];
          end else begin
            blk <= rnd_mix ^ k[127:0];
            k   <= {k[127:0], n0, n1, n2, n3};
            if (rnd[0]) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          end
          rnd <= rnd + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o      = (fsm == IDLE);
  assign bus.v_o          = (fsm == DONE);
  assign bus.ciphertext_o = ct;
endmodule

// File: tb/tb_aes_encryption_multicycle.sv
// Directed known-answer vectors, handshake corner cases, and random blocks
// checked by decrypting them with an independent inverse cipher.
module tb_aes_encryption_multicycle;
  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk = ~clk;

  aes_encryption_multicycle_if bus ();
  aes_encryption_multicycle dut (.clk_i(clk), .reset_n_i(reset_n_i), .bus(bus));

  typedef struct {
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  typedef logic [14:0][127:0] rks_t;

  int total = 0;
  int bad   = 0;
  int proto_err = 0;

  always @(posedge clk)
    if (reset_n_i && bus.yumi_i && !bus.v_o) proto_err++;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // ---------------- inverse-cipher reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01, p = a, e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gm(r, p);
      p = gm(p, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] i = ginv(a);
    return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isb(input logic [7:0] s);
    return ginv(rl(s, 1) ^ rl(s, 3) ^ rl(s, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] sw(input logic [31:0] t);
    return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
  endfunction

  function automatic rks_t expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    rks_t rk;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = isb(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] imc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
      o[119-32*c -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
      o[111-32*c -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
      o[103-32*c -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] decrypt(input logic [255:0] key, input logic [127:0] ct);
    rks_t rk = expand(key);
    logic [127:0] s = ct ^ rk[14];
    for (int r = 13; r >= 1; r--) s = imc(inv_sr_sb(s) ^ rk[r]);
    return inv_sr_sb(s) ^ rk[0];
  endfunction

  function automatic logic [255:0] r256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- transaction driver (called just after a negedge) ----------------
  task automatic run(input logic [255:0] key, input logic [127:0] pt, input bit scramble,
                     input bit hold, output logic [127:0] ct, output int lat);
    int n = 0;
    bus.key_i = key;
    bus.plaintext_i = pt;
    bus.v_i = 1'b1;
    while (!bus.ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.v_i = 1'b0;
    lat = 0;
    while (!bus.v_o && lat < 40) begin
      if (scramble) begin
        bus.key_i = r256();
        bus.plaintext_i = r128();
      end
      @(negedge clk);
      lat++;
    end
    ct = bus.ciphertext_o;
    if (!hold) begin
      bus.yumi_i = 1'b1;
      @(negedge clk);
      bus.yumi_i = 1'b0;
    end
  endtask

  localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P_C3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  vec_t vecs [4];
  logic [127:0] ct;
  int lat;
  bit seen;

  initial begin
    vecs[0] = '{K_C3, P_C3, C_C3};
    vecs[1] = '{256'h0, 128'h0, 128'hdc95c078a2408989ad48a21492842087};
    vecs[2] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'h6bc1bee22e409f96e93d7e117393172a, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8};
    vecs[3] = '{K_C3, P_C3, C_C3};

    bus.key_i = '0;
    bus.plaintext_i = '0;
    bus.v_i = 1'b0;
    bus.yumi_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", bus.ready_o, 1'b1);
    chk("reset_v_o", bus.v_o, 1'b0);
    chk("reset_ct", bus.ciphertext_o, 128'h0);
    reset_n_i = 1'b1;
    @(negedge clk);

    // known-answer vectors, back to back
    for (int i = 0; i < 4; i++) begin
      run(vecs[i].key, vecs[i].pt, 1'b0, 1'b0, ct, lat);
      chk($sformatf("kat%0d_latency", i), lat, 14);
      chk($sformatf("kat%0d_ct", i), ct, vecs[i].ct);
      chk($sformatf("kat%0d_ready_after_yumi", i), bus.ready_o, 1'b1);
    end

    // backpressure: hold the result, v_i pulses must be ignored
    run(K_C3, P_C3, 1'b0, 1'b1, ct, lat);
    chk("bp_first_ct", ct, C_C3);
    for (int i = 0; i < 20; i++) begin
      bus.v_i = i[0];
      bus.key_i = r256();
      bus.plaintext_i = r128();
      @(negedge clk);
      chk("bp_v_o", bus.v_o, 1'b1);
      chk("bp_ct", bus.ciphertext_o, C_C3);
      chk("bp_ready", bus.ready_o, 1'b0);
    end
    // yumi with v_i in the same cycle: only yumi is taken
    bus.v_i = 1'b1;
    bus.yumi_i = 1'b1;
    @(negedge clk);
    bus.v_i = 1'b0;
    bus.yumi_i = 1'b0;
    chk("bp_ready_after_yumi", bus.ready_o, 1'b1);
    chk("bp_v_o_after_yumi", bus.v_o, 1'b0);
    @(negedge clk);
    chk("bp_no_accept_with_yumi", bus.ready_o, 1'b1);

    // asynchronous reset around round 7
    bus.key_i = K_C3;
    bus.plaintext_i = P_C3;
    bus.v_i = 1'b1;
    @(negedge clk);
    bus.v_i = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset_n_i = 1'b0;
    #1;
    chk("midrst_v_o", bus.v_o, 1'b0);
    chk("midrst_ready", bus.ready_o, 1'b1);
    chk("midrst_ct", bus.ciphertext_o, 128'h0);
    @(negedge clk);
    reset_n_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.v_o || !bus.ready_o) seen = 1'b1;
    end
    chk("midrst_quiet", seen, 1'b0);
    run(K_C3, P_C3, 1'b0, 1'b0, ct, lat);
    chk("midrst_after_latency", lat, 14);
    chk("midrst_after_ct", ct, C_C3);

    // inputs change every cycle after accept
    run(K_C3, P_C3, 1'b1, 1'b0, ct, lat);
    chk("scramble_ct", ct, C_C3);

    // random blocks, round-tripped through the inverse cipher
    for (int i = 0; i < 1000; i++) begin
      logic [255:0] k;
      logic [127:0] p;
      k = r256();
      p = r128();
      run(k, p, 1'b0, 1'b0, ct, lat);
      chk($sformatf("rand%0d_roundtrip", i), {lat[7:0], decrypt(k, ct)}, {8'd14, p});
    end

    chk("protocol_yumi_without_v_o", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
